ccip_intr_sequencer: RTL
========================

Name: ccip_intr_sequencer

Overview:
- Sits between the AFU CSR/MMIO decode logic and the CCI-P c1 Tx channel. It owns all interrupt-request generation for the AFU.
- Accepts interrupt trigger pulses for user IDs 0..3 and keeps a per-ID pending/outstanding state.
- Issues eREQ_INTR packets on c1 under c1TxAlmFull backpressure and retires them on the matching eRSP_INTR from c1 Rx.
- Flags timeouts and spurious responses as sticky status for CSR readback.

Parameters:
- TIMEOUT_CYCLES, 65535: cycles an issued interrupt may stay outstanding before it is declared timed out.
- CNT_W, 16: width of the saturating coalesce counter.

Ports:
- Clk_400  in  1  core clock; all logic is synchronous to it.
- SoftReset  in  1  synchronous, active-high reset.
- trig_valid  in  1  one-cycle interrupt trigger from CSR decode.
- trig_id  in  2  user interrupt ID of the trigger.
- vc_sel  in  t_ccip_vc  VC placed in each issued request header.
- cp2af_sRxPort  in  t_if_ccip_Rx  uses c1TxAlmFull, c1.rspValid and c1.hdr only.
- af2cp_c1Tx  out  t_if_ccip_c1_Tx  registered c1 Tx packet.
- pend_vec  out  4  per-ID: triggered but not yet issued.
- outst_vec  out  4  per-ID: issued, awaiting response.
- timeout_err  out  4  per-ID sticky timeout flag.
- spurious_err  out  1  sticky: an eRSP_INTR arrived for a non-outstanding ID.
- coalesce_cnt  out  CNT_W  saturating count of triggers merged into an existing pending entry.
- err_clr  in  1  single-cycle clear of timeout_err, spurious_err and coalesce_cnt.

Behaviour:
- Reset values:
  - all outputs 0: af2cp_c1Tx.valid/hdr/data, pend_vec, outst_vec, timeout_err, spurious_err, coalesce_cnt.
  - all timeout counters 0.
  - round-robin pointer 0.
- Trigger handling (edge N, registered):
  - pend_vec[trig_id] is set at N+1.
  - If it was already 1, the trigger coalesces: coalesce_cnt increments and saturates at all-ones.
  - A trigger is never dropped.
- Issue eligibility: ID i is eligible when pend_vec[i] && !outst_vec[i]. This gives at most one in flight and one queued per ID.
- Arbitration:
  - Round-robin among eligible IDs, starting at the pointer.
  - After a grant of ID g, the pointer becomes g+1 mod 4.
  - At most one issue per cycle, and no issue in a cycle where c1TxAlmFull=1.
- Issue (decided at cycle M, registered):
  - At M+1: af2cp_c1Tx.valid=1; hdr = t_ccip_c1_ReqIntrHdr cast to t_ccip_c1_ReqMemHdr with req_type=eREQ_INTR, id=g, vc_sel=vc_sel, rsvd fields 0; data=0.
  - Also at M+1: pend_vec[g] cleared, outst_vec[g] set, timeout counter g cleared.
  - valid is a single-cycle pulse; hdr and data return to 0 when not issuing.
- Latency: a trigger at edge N with an idle channel and no almFull produces a Tx packet at N+2.
- Response:
  - Condition: cp2af_sRxPort.c1.rspValid with resp_type==eRSP_INTR and hdr id = r.
  - If outst_vec[r] is set, it is cleared next cycle.
  - Otherwise spurious_err is set.
  - All other c1 response types are ignored.
- Timeout:
  - While outst_vec[i] is set, counter i increments every cycle.
  - When the counter reaches TIMEOUT_CYCLES: timeout_err[i] is set, outst_vec[i] is cleared and the counter is reset.
  - A late response after that is therefore spurious.
- Simultaneous events:
  - Trigger and response for the same ID in one cycle: outst clears and pend sets. The ID reissues normally.
  - Trigger for an ID being issued in the same cycle: pend_vec stays 1 (a new request is queued) and coalesce_cnt is unchanged.
  - Response and timeout expiry for the same ID in one cycle: the response wins and no timeout_err is set.
  - err_clr in the same cycle as a new error or coalesce: the new event wins (its bit or count of 1 is set).
- c1TxAlmFull:
  - Sampled combinationally in the arbitration cycle.
  - Pending entries are held indefinitely under backpressure.
  - Timeout counters for outstanding IDs keep running.
- Reset mid-operation: SoftReset discards all pending and outstanding state. Responses arriving after reset are reported as spurious.

Decomposition:
- Shared package (ccip_intr_pkg):
  - NUM_INTR_IDS=4.
  - typedef t_intr_id (logic [1:0]).
  - function building the eREQ_INTR c1 packet.
  - Timeout and coalesce-count width constants.
- One sub-module, ccip_intr_rr_arb: a 4-way round-robin arbiter with inputs req[3:0] and en, outputs gnt_valid and gnt_id, and an internal pointer.

Test Plan:
- Trigger id=2, almFull=0 → at N+2, Tx valid=1, req_type=eREQ_INTR, id=2, vc_sel echoed; outst_vec=4'b0100; eRSP_INTR id=2 clears it next cycle.
- Triggers for ids 0,1,2,3 on the same edge region → four packets on consecutive cycles in order 0,1,2,3; a second round with pointer=0 again yields 0,1,2,3.
- almFull=1 for 20 cycles with id=1 triggered → no Tx valid for those cycles; Tx issues 1 cycle after almFull drops.
- Three triggers for id=3 while id=3 is outstanding → one queued issue after the response, coalesce_cnt=2.
- TIMEOUT_CYCLES=8, no response to id=0 → timeout_err=4'b0001 and outst_vec[0]=0 after 8 cycles; a later eRSP_INTR id=0 sets spurious_err; err_clr clears both.
- SoftReset asserted while id=1 is pending and id=2 is outstanding → all outputs 0 the next cycle; no Tx is issued afterwards.

Source files
------------

// File: rtl/ccip_intr_pkg.sv
// Shared types for the CCI-P interrupt sequencer: a local subset of the CCI-P
// c1 channel structures, interrupt ID type, widths and the request-packet builder.
package ccip_intr_pkg;

    localparam int NUM_INTR_IDS       = 4;
    localparam int TMO_CNT_W          = 16;
    localparam int COAL_CNT_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef logic [1:0] t_intr_id;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        logic [1:0]   cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    // Same 80-bit layout as the memory header, with the interrupt ID in the low bits
    typedef struct packed {
        logic [5:0]   rsvd1;
        t_ccip_vc     vc_sel;
        logic [3:0]   rsvd0;
        t_ccip_c1_req req_type;
        logic [61:0]  rsvd2;
        t_intr_id     id;
    } t_ccip_c1_ReqIntrHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [3:0]   rsvd0;
        t_ccip_c1_rsp resp_type;
        logic [13:0]  rsvd2;
        t_intr_id     id;
    } t_ccip_c1_RspIntrHdr;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    function automatic t_if_ccip_c1_Tx build_intr_pkt(input t_intr_id id, input t_ccip_vc vc);
        t_ccip_c1_ReqIntrHdr h;
        t_if_ccip_c1_Tx      p;
        h          = '0;
        h.vc_sel   = vc;
        h.req_type = eREQ_INTR;
        h.id       = id;
        p          = '0;
        p.hdr      = t_ccip_c1_ReqMemHdr'(h);
        p.valid    = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/ccip_intr_rr_arb.sv
// Four-way round-robin arbiter; the grant is combinational and the pointer
// advances past the granted ID only when a grant is actually taken.
module ccip_intr_rr_arb
    import ccip_intr_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_INTR_IDS-1:0] req,
    input  logic                    en,
    output logic                    gnt_valid,
    output t_intr_id                gnt_id
);

    t_intr_id r_ptr;
    t_intr_id w_idx;

    // Scan from the highest offset down so the closest requester to the pointer wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = r_ptr;
        w_idx     = r_ptr;
        for (int k = NUM_INTR_IDS - 1; k >= 0; k--) begin
            w_idx = r_ptr + t_intr_id'(k);
            if (req[w_idx]) begin
                gnt_valid = en;
                gnt_id    = w_idx;
            end else begin
                gnt_valid = gnt_valid;
                gnt_id    = gnt_id;
            end
        end
    end

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (gnt_valid) begin
            r_ptr <= gnt_id + 2'd1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/ccip_intr_sequencer.sv
// AFU interrupt sequencer: tracks per-ID pending/outstanding state, issues
// eREQ_INTR on CCI-P c1 Tx, retires on eRSP_INTR and reports timeouts/spurious responses.
module ccip_intr_sequencer
    import ccip_intr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = COAL_CNT_W
) (
    input  logic                    Clk_400,
    input  logic                    SoftReset,
    input  logic                    trig_valid,
    input  logic [1:0]              trig_id,
    input  t_ccip_vc                vc_sel,
    input  t_if_ccip_Rx             cp2af_sRxPort,
    output t_if_ccip_c1_Tx          af2cp_c1Tx,
    output logic [NUM_INTR_IDS-1:0] pend_vec,
    output logic [NUM_INTR_IDS-1:0] outst_vec,
    output logic [NUM_INTR_IDS-1:0] timeout_err,
    output logic                    spurious_err,
    output logic [CNT_W-1:0]        coalesce_cnt,
    input  logic                    err_clr
);

    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [NUM_INTR_IDS-1:0] r_pend;
    logic [NUM_INTR_IDS-1:0] r_outst;
    logic [NUM_INTR_IDS-1:0] r_tmo_err;
    logic                    r_spur;
    logic [CNT_W-1:0]        r_coal;
    logic [TMO_W-1:0]        r_tmo_cnt [NUM_INTR_IDS];
    t_if_ccip_c1_Tx          r_tx;

    logic                    w_gnt_valid;
    t_intr_id                w_gnt_id;
    logic [NUM_INTR_IDS-1:0] w_eligible;
    logic [NUM_INTR_IDS-1:0] w_gnt_oh;
    logic [NUM_INTR_IDS-1:0] w_trig_oh;
    logic [NUM_INTR_IDS-1:0] w_rsp_oh;
    logic [NUM_INTR_IDS-1:0] w_rsp_hit;
    logic [NUM_INTR_IDS-1:0] w_expire;
    logic                    w_rsp_intr;
    logic                    w_spur_evt;
    logic                    w_coalesce;
    t_ccip_c1_RspIntrHdr     w_rsp_hdr;
    logic                    w_unused;

    assign w_eligible = r_pend & ~r_outst;

    ccip_intr_rr_arb u_arb (
        .clk       (Clk_400),
        .rst       (SoftReset),
        .req       (w_eligible),
        .en        (!cp2af_sRxPort.c1TxAlmFull),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    // Event decode: trigger, grant, response and timeout expiry as per-ID vectors
    always_comb begin
        w_rsp_hdr  = t_ccip_c1_RspIntrHdr'(cp2af_sRxPort.c1.hdr);
        w_rsp_intr = cp2af_sRxPort.c1.rspValid && (w_rsp_hdr.resp_type == eRSP_INTR);
        w_trig_oh  = '0;
        w_gnt_oh   = '0;
        w_rsp_oh   = '0;
        if (trig_valid) begin
            w_trig_oh[trig_id] = 1'b1;
        end else begin
            w_trig_oh = '0;
        end
        if (w_gnt_valid) begin
            w_gnt_oh[w_gnt_id] = 1'b1;
        end else begin
            w_gnt_oh = '0;
        end
        w_rsp_oh[w_rsp_hdr.id] = w_rsp_intr;
        w_rsp_hit  = w_rsp_oh & r_outst;
        w_spur_evt = w_rsp_intr && !r_outst[w_rsp_hdr.id];
        // A trigger landing on the entry being issued queues a fresh request, not a merge
        w_coalesce = trig_valid && r_pend[trig_id] && !(w_gnt_valid && (w_gnt_id == trig_id));
        for (int i = 0; i < NUM_INTR_IDS; i++) begin
            w_expire[i] = r_outst[i] && !w_rsp_oh[i] && ((r_tmo_cnt[i] + TMO_W'(1)) == TMO_LIMIT);
        end
    end

    assign w_unused = ^{cp2af_sRxPort.c0TxAlmFull, w_rsp_hdr.vc_used, w_rsp_hdr.rsvd1,
                        w_rsp_hdr.hit_miss, w_rsp_hdr.rsvd0, w_rsp_hdr.rsvd2};

    // Per-ID state, sticky status, coalesce counter and the registered Tx packet
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            r_pend    <= '0;
            r_outst   <= '0;
            r_tmo_err <= '0;
            r_spur    <= 1'b0;
            r_coal    <= '0;
            r_tx      <= '0;
            for (int i = 0; i < NUM_INTR_IDS; i++) begin
                r_tmo_cnt[i] <= '0;
            end
        end else begin
            r_pend    <= (r_pend & ~w_gnt_oh) | w_trig_oh;
            r_outst   <= (r_outst | w_gnt_oh) & ~w_rsp_hit & ~w_expire;
            r_tmo_err <= (err_clr ? '0 : r_tmo_err) | w_expire;
            r_spur    <= (r_spur && !err_clr) || w_spur_evt;
            if (w_coalesce) begin
                r_coal <= err_clr ? CNT_W'(1) : ((r_coal == CNT_MAX) ? CNT_MAX : r_coal + CNT_W'(1));
            end else if (err_clr) begin
                r_coal <= '0;
            end else begin
                r_coal <= r_coal;
            end
            for (int i = 0; i < NUM_INTR_IDS; i++) begin
                if (!r_outst[i] || w_gnt_oh[i] || w_expire[i] || w_rsp_hit[i]) begin
                    r_tmo_cnt[i] <= '0;
                end else begin
                    r_tmo_cnt[i] <= r_tmo_cnt[i] + TMO_W'(1);
                end
            end
            r_tx <= w_gnt_valid ? build_intr_pkt(w_gnt_id, vc_sel) : '0;
        end
    end

    assign af2cp_c1Tx   = r_tx;
    assign pend_vec     = r_pend;
    assign outst_vec    = r_outst;
    assign timeout_err  = r_tmo_err;
    assign spurious_err = r_spur;
    assign coalesce_cnt = r_coal;

endmodule
